// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment loopback decoder.
//   SEG7_GLYPH holds the 16 legal active-low hex glyphs, indexed by nibble
//   value. Bit order is [0:6] = segments a..g, 0 = lit. The display driver
//   uses the same table, so the encode and decode paths cannot drift apart.
//   seg7_state_t is the encoder FSM state.
package seg7_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } seg7_state_t;

   // Each literal is written a..g from left to right. The leftmost bit
   // therefore lands on index 0, which is segment a.
   localparam logic [0:6] SEG7_GLYPH [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0001100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/seg7_lookup.sv
// seg7_lookup
//   Combinational reverse lookup from a 7-segment pattern to a hex nibble.
//   Ports:
//     pattern  in   [0:6]  active-low pattern, index 0 = segment a
//     nibble   out  [3:0]  matching hex value, or 0 when there is no match
//     hit      out  1      pattern is one of the 16 legal glyphs
module seg7_lookup
   import seg7_pkg::*;
(
   input  logic [0:6] pattern,
   output logic [3:0] nibble,
   output logic       hit
);

   // The glyph codes are unique, so at most one entry can match.
   always_comb begin
      nibble = 4'h0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG7_GLYPH[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_encoder.sv
// seg7_encoder
//   Reads back 7-segment display patterns, decodes them into hex nibbles and
//   packs DIGITS nibbles into one word. The first accepted digit ends up in
//   the most significant nibble.
//   Ports:
//     Clk       in   1          clock, rising edge
//     Reset     in   1          synchronous, active-high
//     SegIn     in   [0:6]      pattern, index 0 = segment a, 0 = lit
//     SegValid  in   1          SegIn carries a pattern
//     SegReady  out  1          block can take a pattern (COLLECT, not in reset)
//     Value     out  4*DIGITS   assembled word
//     ErrMask   out  DIGITS     bit i set = nibble i came from an illegal pattern
//     OutValid  out  1          Value/ErrMask hold a complete word
//     OutReady  in   1          consumer takes the word
//     StateDbg  out  enum       current FSM state, for observation only
//
//   Handshake: on both the input and the output side, an item moves on a
//   rising edge where valid and ready are both high. While valid is high and
//   ready is low, the producer holds its data stable. SegReady is low in HOLD,
//   so a digit can never be accepted on the same cycle as a word handoff.
module seg7_encoder
   import seg7_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [0:6]          SegIn,
   input  logic                SegValid,
   output logic                SegReady,
   output logic [4*DIGITS-1:0] Value,
   output logic [DIGITS-1:0]   ErrMask,
   output logic                OutValid,
   input  logic                OutReady,
   output seg7_state_t         StateDbg
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   seg7_state_t       state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [W-1:0]      shreg;
   logic [DIGITS-1:0] errw;

   logic [3:0]        nibble;
   logic              hit;
   logic              xfer;
   logic              last;
   logic [W-1:0]      word_nxt;
   logic [DIGITS-1:0] err_nxt;

   seg7_lookup u_lookup (
      .pattern (SegIn),
      .nibble  (nibble),
      .hit     (hit)
   );

   assign xfer = SegValid && SegReady;
   assign last = (cnt == CW'(DIGITS - 1));

   // Working word after this digit shifts in. When DIGITS = 1 the shift
   // empties the register, so the word is just the new nibble.
   assign word_nxt = (shreg << 4) | W'(nibble);
   assign err_nxt  = (errw << 1) | DIGITS'(!hit);

   assign StateDbg = state;

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Reset) state <= COLLECT;
      else       state <= state_nxt;
   end

   // FSM next state and ready
   always_comb begin
      state_nxt = state;
      SegReady  = 1'b0;
      case (state)
         COLLECT: begin
            SegReady = !Reset;
            if (SegValid && !Reset && last) state_nxt = HOLD;
         end
         HOLD: begin
            if (OutReady) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Counter, working registers and output word
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt      <= '0;
         shreg    <= '0;
         errw     <= '0;
         Value    <= '0;
         ErrMask  <= '0;
         OutValid <= 1'b0;
      end else if (xfer) begin
         if (last) begin
            Value    <= word_nxt;
            ErrMask  <= err_nxt;
            OutValid <= 1'b1;
            cnt      <= '0;
            shreg    <= '0;
            errw     <= '0;
         end else begin
            shreg <= word_nxt;
            errw  <= err_nxt;
            cnt   <= cnt + CW'(1);
         end
      end else if (state == HOLD && OutReady) begin
         // Value and ErrMask keep the last word. Only the qualifier drops.
         OutValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_encoder.sv
// tb_seg7_encoder
//   Directed and random stimulus for a DIGITS=4 instance. A glyph sweep
//   drives a DIGITS=1 instance. Expected words are queued as stimulus is
//   issued, and monitors pop and compare them on each output handoff.
module tb_seg7_encoder;
   import seg7_pkg::*;

   // clock / reset
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset;
   logic [0:6]  SegIn;
   logic        SegValid;
   logic        SegReady;
   logic [15:0] Value;
   logic [3:0]  ErrMask;
   logic        OutValid;
   logic        OutReady;
   seg7_state_t state_dbg;

   logic [0:6]  SegIn1;
   logic        SegValid1;
   logic        SegReady1;
   logic [3:0]  Value1;
   logic [0:0]  ErrMask1;
   logic        OutValid1;
   logic        OutReady1;
   seg7_state_t state_dbg1;

   seg7_encoder #(.DIGITS(4)) dut (
      .Clk(Clk), .Reset(Reset), .SegIn(SegIn), .SegValid(SegValid),
      .SegReady(SegReady), .Value(Value), .ErrMask(ErrMask),
      .OutValid(OutValid), .OutReady(OutReady), .StateDbg(state_dbg)
   );

   seg7_encoder #(.DIGITS(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .SegIn(SegIn1), .SegValid(SegValid1),
      .SegReady(SegReady1), .Value(Value1), .ErrMask(ErrMask1),
      .OutValid(OutValid1), .OutReady(OutReady1), .StateDbg(state_dbg1)
   );

   // hand-entered glyph table, a..g left to right
   logic [0:6] tb_glyph [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];   // {ErrMask, Value} for the DIGITS=4 instance
   logic [4:0]  exp1_q[$];  // {ErrMask, Value} for the DIGITS=1 instance
   logic [19:0] e4;
   logic [4:0]  e1;
   logic        rand_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // {err, nibble} for a pattern
   function automatic logic [4:0] decode(input logic [0:6] p);
      for (int i = 0; i < 16; i++)
         if (tb_glyph[i] == p) return {1'b0, 4'(i)};
      return 5'b10000;
   endfunction

   // scoreboard monitors
   always @(negedge Clk) begin
      if (Reset === 1'b0 && OutValid === 1'b1 && OutReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL word4_extra: got %h/%b want no word", Value, ErrMask);
         end else begin
            e4 = exp_q.pop_front();
            check("word4_value", 32'(Value), 32'(e4[15:0]));
            check("word4_err", 32'(ErrMask), 32'(e4[19:16]));
         end
      end
   end

   always @(negedge Clk) begin
      if (Reset === 1'b0 && OutValid1 === 1'b1 && OutReady1 === 1'b1) begin
         if (exp1_q.size() == 0) begin
            total++; bad++;
            $display("FAIL word1_extra: got %h/%b want no word", Value1, ErrMask1);
         end else begin
            e1 = exp1_q.pop_front();
            check("word1_value", 32'(Value1), 32'(e1[3:0]));
            check("word1_err", 32'(ErrMask1), 32'(e1[4]));
         end
      end
   end

   // driver tasks: called at posedge+1, return at posedge+1 after acceptance
   task automatic send(input logic [0:6] p);
      int  n;
      logic got;
      SegIn    = p;
      SegValid = 1'b1;
      n = 0;
      forever begin
         @(negedge Clk);
         got = SegReady;
         @(posedge Clk);
         #1;
         if (got) break;
         n++;
         if (n > 100) begin
            total++; bad++;
            $display("FAIL send_timeout: got SegReady=0 want SegReady=1");
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      SegValid = 1'b0;
      SegIn    = 7'($urandom_range(0, 127));
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send1(input logic [0:6] p);
      int  n;
      logic got;
      SegIn1    = p;
      SegValid1 = 1'b1;
      n = 0;
      forever begin
         @(negedge Clk);
         got = SegReady1;
         @(posedge Clk);
         #1;
         if (got) break;
         n++;
         if (n > 100) begin
            total++; bad++;
            $display("FAIL send1_timeout: got SegReady=0 want SegReady=1");
            break;
         end
      end
      SegValid1 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 2000) begin
         @(posedge Clk);
         #1;
         n++;
      end
      check(name, 32'(exp_q.size() + exp1_q.size()), 32'd0);
   endtask

   // watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   // main sequence
   initial begin
      logic [15:0] ev;
      logic [3:0]  ee;
      logic [4:0]  dec;
      logic [0:6]  p;
      int          g;

      Reset = 1'b1; SegIn = '0; SegValid = 1'b0; OutReady = 1'b0;
      SegIn1 = '0; SegValid1 = 1'b0; OutReady1 = 1'b1;
      rand_done = 1'b0;

      // reset state
      @(posedge Clk); #1;
      @(negedge Clk);
      check("rst_value", 32'(Value), 32'h0);
      check("rst_err", 32'(ErrMask), 32'h0);
      check("rst_valid", 32'(OutValid), 32'h0);
      check("rst_ready", 32'(SegReady), 32'h0);
      check("rst_state", 32'(state_dbg), 32'(COLLECT));
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      check("post_rst_ready", 32'(SegReady), 32'h1);
      @(posedge Clk); #1;
      OutReady = 1'b1;

      // 3 A b 0, back to back
      exp_q.push_back({4'b0000, 16'h3AB0});
      send(7'b0000110); send(7'b0001000); send(7'b1100000); send(7'b0000001);
      idle(0);
      @(negedge Clk);
      check("t1_valid_hi", 32'(OutValid), 32'h1);
      check("t1_ready_lo", 32'(SegReady), 32'h0);
      @(negedge Clk);
      check("t1_valid_lo", 32'(OutValid), 32'h0);
      check("t1_ready_hi", 32'(SegReady), 32'h1);
      @(posedge Clk); #1;

      // 1, blank, F, 6
      exp_q.push_back({4'b0100, 16'h10F6});
      send(7'b1001111); send(7'b1111111); send(7'b0111000); send(7'b0100000);
      idle(2);

      // hold with OutReady low while the next digit waits
      OutReady = 1'b0;
      exp_q.push_back({4'b0000, 16'hCDEF});
      send(7'b0110001); send(7'b1000010); send(7'b0110000); send(7'b0111000);
      SegIn = 7'b0001100;  // 9, held valid through the stall
      SegValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check("hold_ready", 32'(SegReady), 32'h0);
         check("hold_valid", 32'(OutValid), 32'h1);
         check("hold_value", 32'(Value), 32'hCDEF);
         @(posedge Clk); #1;
      end
      OutReady = 1'b1;
      @(negedge Clk);
      check("handoff_ready", 32'(SegReady), 32'h0);
      @(posedge Clk); #1;
      exp_q.push_back({4'b0000, 16'h9123});
      @(negedge Clk);
      check("after_handoff_ready", 32'(SegReady), 32'h1);
      @(posedge Clk); #1;   // digit 9 accepted here
      send(7'b1001111); send(7'b0010010); send(7'b0000110);
      idle(2);

      // reset mid-word
      send(7'b1001111); send(7'b0010010);
      idle(0);
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      check("midrst_value", 32'(Value), 32'h0);
      check("midrst_err", 32'(ErrMask), 32'h0);
      check("midrst_valid", 32'(OutValid), 32'h0);
      check("midrst_ready", 32'(SegReady), 32'h1);
      @(posedge Clk); #1;
      exp_q.push_back({4'b0000, 16'h5678});
      send(7'b0100100); send(7'b0100000); send(7'b0001111); send(7'b0000000);
      idle(2);
      drain("directed_drain");

      // random gaps and back-pressure
      fork
         begin
            while (!rand_done) begin
               @(posedge Clk); #1;
               OutReady = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int w = 0; w < 1000; w++) begin
               ev = '0; ee = '0;
               for (int d = 0; d < 4; d++) begin
                  if ($urandom_range(0, 3) == 0) p = 7'($urandom_range(0, 127));
                  else                           p = tb_glyph[$urandom_range(0, 15)];
                  dec = decode(p);
                  ev = {ev[11:0], dec[3:0]};
                  ee = {ee[2:0], dec[4]};
                  if (d == 3) exp_q.push_back({ee, ev});
                  g = $urandom_range(0, 2);
                  if (g != 0) idle(g);
                  send(p);
               end
            end
            idle(0);
            drain("random_drain");
            rand_done = 1'b1;
         end
      join
      OutReady = 1'b1;

      // DIGITS=1: legal glyphs, then every pattern
      for (int i = 0; i < 16; i++) begin
         exp1_q.push_back({1'b0, 4'(i)});
         send1(tb_glyph[i]);
      end
      for (int i = 0; i < 128; i++) begin
         p = 7'(i);
         exp1_q.push_back(decode(p));
         send1(p);
      end
      idle(2);
      drain("sweep_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
